// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, error codes and byte constants for the PS/2 host sequencer
package ps2_pkg;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_SHIFT     = 3'd2;
    localparam logic [2:0] ST_ACK_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP_WAIT = 3'd4;

    localparam logic [1:0] ERR_NONE             = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT          = 2'd1;
    localparam logic [1:0] ERR_NO_ACK           = 2'd2;
    localparam logic [1:0] ERR_RESEND_EXHAUSTED = 2'd3;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizers for PS2_CLK/PS2_DAT plus clock falling-edge pulse
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    input  logic dat_in,
    output logic dat_s,
    output logic fall_pulse
);
    // clk_sr[2] is one cycle behind the synchronized level clk_sr[1]
    logic [2:0] clk_sr;
    logic [1:0] dat_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sr <= 3'b111;
            dat_sr <= 2'b11;
        end else begin
            clk_sr <= {clk_sr[1:0], clk_in};
            dat_sr <= {dat_sr[0], dat_in};
        end
    end

    assign dat_s      = dat_sr[1];
    assign fall_pulse = clk_sr[2] & ~clk_sr[1];
endmodule

// File: rtl/ps2_host_cmd_seq.sv
// rtl/ps2_host_cmd_seq.sv - PS/2 host-to-device command sequencer with line ACK and resend handling
module ps2_host_cmd_seq
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 2);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    tx_byte;
    logic [7:0]    arg_byte;
    logic          arg_pending;
    logic          dat_drive;
    logic [RW-1:0] retry;
    logic          dat_s;
    logic          fall_pulse;
    logic          inhibit_last;
    logic          timeout;

    ps2_line_sync u_sync (
        .clk        (CLOCK_50),
        .reset      (reset),
        .clk_in     (ps2_clk_in),
        .dat_in     (ps2_dat_in),
        .dat_s      (dat_s),
        .fall_pulse (fall_pulse)
    );

    assign inhibit_last = (cnt == CW'(INHIBIT_CYC - 1));
    assign timeout      = (cnt == CW'(TIMEOUT_CYC - 1));

    // Line enables decode from state so any return to IDLE releases both lines on that edge.
    assign cmd_ready  = (state == ST_IDLE) && !reset;
    assign ps2_clk_oe = (state == ST_INHIBIT);
    assign ps2_dat_oe = ((state == ST_INHIBIT) && inhibit_last) || ((state == ST_SHIFT) && dat_drive);
    assign rx_inhibit = (state == ST_INHIBIT) || (state == ST_SHIFT) || (state == ST_ACK_WAIT);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            tx_byte     <= '0;
            arg_byte    <= '0;
            arg_pending <= 1'b0;
            dat_drive   <= 1'b0;
            retry       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            cnt  <= cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (cmd_valid) begin
                        tx_byte     <= cmd_byte;
                        arg_byte    <= cmd_arg;
                        arg_pending <= cmd_has_arg;
                        retry       <= '0;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inhibit_last) begin
                        state     <= ST_SHIFT;
                        cnt       <= '0;
                        bit_idx   <= '0;
                        dat_drive <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (fall_pulse) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx < 4'd8) begin
                            dat_drive <= ~tx_byte[bit_idx[2:0]];
                        end else if (bit_idx == 4'd8) begin
                            dat_drive <= ~odd_parity(tx_byte);
                        end else begin
                            dat_drive <= 1'b0;
                            state     <= ST_ACK_WAIT;
                        end
                    end else if (timeout) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end
                end
                ST_ACK_WAIT: begin
                    if (fall_pulse) begin
                        if (!dat_s) begin
                            state <= ST_RESP_WAIT;
                            cnt   <= '0;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_NO_ACK;
                            state    <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end
                end
                ST_RESP_WAIT: begin
                    // Bytes other than ACK/RESEND are scan codes and are let through untouched.
                    if (rx_valid && rx_data == PS2_ACK) begin
                        if (arg_pending) begin
                            tx_byte     <= arg_byte;
                            arg_pending <= 1'b0;
                            retry       <= '0;
                            cnt         <= '0;
                            state       <= ST_INHIBIT;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else if (rx_valid && rx_data == PS2_RESEND) begin
                        if (retry < RW'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            cnt   <= '0;
                            state <= ST_INHIBIT;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_RESEND_EXHAUSTED;
                            state    <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_cmd_seq.sv
// tb/tb_ps2_host_cmd_seq.sv - scoreboard bench with a PS/2 device model for ps2_host_cmd_seq
module tb_ps2_host_cmd_seq;
    localparam int INH  = 40;
    localparam int TO   = 2000;
    localparam int MAXR = 3;
    localparam int H    = 12;
    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_NOCLK  = 2;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_inhibit;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line;
    logic       dat_line;

    assign clk_line = ~ps2_clk_oe & ~dev_clk_low;
    assign dat_line = ~ps2_dat_oe & ~dev_dat_low;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   dev_mode = M_NORMAL;
    bit   dev_quiet = 1'b0;
    int   frames_rx = 0;
    int   fall11_cyc = 0;
    int   t_shift = 0;
    int   t_last_ev = 0;
    ev_t        exp_ev_q[$];
    logic [7:0] exp_frame_q[$];
    logic [7:0] reply_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_cmd_seq #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .MAX_RETRY(MAXR)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_byte    (cmd_byte),
        .cmd_has_arg (cmd_has_arg),
        .cmd_arg     (cmd_arg),
        .ps2_clk_in  (clk_line),
        .ps2_dat_in  (dat_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_inhibit  (rx_inhibit),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic check(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send, clocks 10 bits in, ACKs, then replies via the receiver port.
    initial begin : device
        logic [9:0] bits;
        logic [7:0] exp_b;
        logic [7:0] sc;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!clk_line) begin
                for (int k = 0; k < 4 * TO && !(clk_line && !dat_line); k++) @(negedge clk);
                if (dev_mode != M_NOCLK && clk_line && !dat_line) begin
                    repeat (6) @(negedge clk);
                    for (int i = 0; i < 10; i++) begin
                        dev_clk_low = 1'b1;
                        repeat (H) @(negedge clk);
                        dev_clk_low = 1'b0;
                        bits[i] = dat_line;
                        repeat (H) @(negedge clk);
                    end
                    if (dev_mode != M_NOACK) dev_dat_low = 1'b1;
                    repeat (2) @(negedge clk);
                    if (!dev_quiet) check("rx_inhibit_in_frame", int'(rx_inhibit), 1);
                    fall11_cyc  = cyc;
                    dev_clk_low = 1'b1;
                    repeat (H) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (H) @(negedge clk);
                    dev_dat_low = 1'b0;
                    if (!dev_quiet) begin
                        frames_rx++;
                        check("frame_expected", int'(exp_frame_q.size() != 0), 1);
                        if (exp_frame_q.size() != 0) begin
                            exp_b = exp_frame_q.pop_front();
                            check("frame_data", int'(bits[7:0]), int'(exp_b));
                            check("frame_parity", int'(bits[8]), ($countones(exp_b) % 2 == 0) ? 1 : 0);
                            check("frame_stop", int'(bits[9]), 1);
                        end
                        if (dev_mode == M_NORMAL && reply_q.size() != 0) begin
                            repeat (10) @(negedge clk);
                            if ($urandom_range(0, 1) == 1) begin
                                do sc = 8'($urandom_range(0, 255)); while (sc == 8'hFA || sc == 8'hFE);
                                send_rx(sc);
                                repeat (3) @(negedge clk);
                            end
                            send_rx(reply_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin : ev_mon
        ev_t e;
        forever begin
            @(negedge clk);
            if (done || err) begin
                t_last_ev = cyc;
                check("done_err_exclusive", int'(done & err), 0);
                if (exp_ev_q.size() == 0) begin
                    check("unexpected_event", int'({done, err}), 0);
                end else begin
                    e = exp_ev_q.pop_front();
                    check("event_kind_err", int'(err), int'(e.is_err));
                    if (e.is_err) check("err_code", int'(err_code), int'(e.code));
                end
            end
        end
    end

    initial begin : oe_mon
        int   run;
        logic prev_clk;
        logic prev_dat;
        run = 0;
        prev_clk = 1'b0;
        prev_dat = 1'b0;
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                run++;
            end else if (prev_clk) begin
                check("inhibit_len", run, INH);
                check("start_bit_with_clk_oe", int'(prev_dat), 1);
                t_shift = cyc;
                run = 0;
            end
            prev_clk = ps2_clk_oe;
            prev_dat = ps2_dat_oe;
        end
    end

    task automatic issue(input logic [7:0] c, input logic ha, input logic [7:0] a);
        for (int k = 0; k < 1000 && !cmd_ready; k++) @(negedge clk);
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_byte    = c;
        cmd_has_arg = ha;
        cmd_arg     = a;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
    endtask

    // Reference: walk the device's reply script frame by frame to get frames sent and final outcome.
    task automatic run_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a,
                           input int fe1, input int fe2, input int mode, input bit poke);
        logic [7:0] cur;
        bit         pend;
        bit         fin;
        int         retries;
        int         fe_left;
        int         nfr;
        cur = c; pend = ha; fin = 1'b0; retries = 0; fe_left = fe1; nfr = 0;
        reply_q.delete();
        if (mode == M_NOCLK) begin
            exp_ev_q.push_back('{1'b1, 2'd1});
        end else if (mode == M_NOACK) begin
            exp_frame_q.push_back(c);
            nfr = 1;
            exp_ev_q.push_back('{1'b1, 2'd2});
        end else begin
            while (!fin) begin
                exp_frame_q.push_back(cur);
                nfr++;
                if (fe_left > 0) begin
                    reply_q.push_back(8'hFE);
                    fe_left--;
                    if (retries == MAXR) begin
                        exp_ev_q.push_back('{1'b1, 2'd3});
                        fin = 1'b1;
                    end else begin
                        retries++;
                    end
                end else begin
                    reply_q.push_back(8'hFA);
                    if (pend) begin
                        cur = a; pend = 1'b0; retries = 0; fe_left = fe2;
                    end else begin
                        exp_ev_q.push_back('{1'b0, 2'd0});
                        fin = 1'b1;
                    end
                end
            end
        end
        dev_mode  = mode;
        frames_rx = 0;
        issue(c, ha, a);
        if (poke) begin
            repeat (10) @(negedge clk);
            check("busy_cmd_ready", int'(cmd_ready), 0);
            cmd_byte  = ~c;
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        for (int k = 0; k < 20000 && exp_ev_q.size() != 0; k++) @(negedge clk);
        check("events_drained", exp_ev_q.size(), 0);
        if (mode == M_NOACK) check("noack_at_11th_fall", int'(t_last_ev - fall11_cyc >= 2 && t_last_ev - fall11_cyc <= 4), 1);
        if (mode == M_NOCLK) check("timeout_latency", t_last_ev - t_shift, TO);
        repeat (300) @(negedge clk);
        check("frame_count", frames_rx, nfr);
        check("frames_pending", exp_frame_q.size(), 0);
        exp_frame_q.delete();
        dev_mode = M_NORMAL;
    endtask

    initial begin : main
        logic [7:0] rc;
        logic [7:0] ra;
        reset = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_has_arg = 1'b0; cmd_arg = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_dat_oe", int'(ps2_dat_oe), 0);
        check("rst_rx_inhibit", int'(rx_inhibit), 0);
        check("rst_done_err", int'({done, err}), 0);
        check("rst_err_code", int'(err_code), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", int'(cmd_ready), 1);

        run_cmd(8'hFF, 1'b0, 8'h00, 0, 0, M_NORMAL, 1'b0);
        run_cmd(8'hED, 1'b1, 8'h07, 0, 0, M_NORMAL, 1'b0);
        run_cmd(8'hED, 1'b0, 8'h00, 3, 0, M_NORMAL, 1'b0);
        run_cmd(8'hED, 1'b0, 8'h00, 4, 0, M_NORMAL, 1'b0);
        run_cmd(8'hF4, 1'b0, 8'h00, 0, 0, M_NOACK,  1'b0);
        run_cmd(8'hF2, 1'b0, 8'h00, 0, 0, M_NOCLK,  1'b0);

        dev_quiet = 1'b1;
        issue(8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 2000 && !ps2_clk_oe; k++) @(negedge clk);
        for (int k = 0; k < 2000 && ps2_clk_oe; k++) @(negedge clk);
        repeat (86) @(negedge clk);
        check("rst_pre_dat_oe", int'(ps2_dat_oe), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_mid_dat_oe", int'(ps2_dat_oe), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", int'(cmd_ready), 1);
        repeat (400) @(negedge clk);
        dev_quiet = 1'b0;

        run_cmd(8'hF4, 1'b0, 8'h00, 0, 0, M_NORMAL, 1'b1);

        for (int r = 0; r < 6; r++) begin
            rc = 8'($urandom_range(0, 255));
            ra = 8'($urandom_range(0, 255));
            run_cmd(rc, 1'($urandom_range(0, 1)), ra, $urandom_range(0, 4), $urandom_range(0, 4), M_NORMAL, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ps2_host_cmd_seq.md
Name: ps2_host_cmd_seq

Overview:
- Host-to-device command sequencer for the PS/2 port on the CLOCK_50 design.
- Accepts a command byte, with an optional argument byte (e.g. 0xED + LED mask, 0xFF reset), from board logic.
- Performs the PS/2 request-to-send and clocks the frame out to the device by open-drain drive-low enables, then checks the line ACK and the device's 0xFA response.
- Runs alongside the existing PS/2 receiver, whose decoded bytes it consumes for response checking.

Parameters:
- INHIBIT_CYC, 5000, CLOCK_50 cycles PS2_CLK is held low before request-to-send (100 us).
- TIMEOUT_CYC, 1000000, maximum cycles waiting for device clocking, ACK, or response byte (20 ms).
- MAX_RETRY, 3, number of resends allowed after receiving 0xFE.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_byte  in  8  command byte
- cmd_has_arg  in  1  an argument byte follows the command
- cmd_arg  in  8  argument byte
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous)
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release
- ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release
- rx_valid  in  1  one-cycle pulse from the receiver
- rx_data  in  8  received byte
- rx_inhibit  out  1  receiver must discard frames while high (INHIBIT through ACK_WAIT)
- done  out  1  one-cycle pulse: command (and argument) acknowledged with 0xFA
- err  out  1  one-cycle pulse on failure
- err_code  out  2  1 TIMEOUT, 2 NO_ACK, 3 RESEND_EXHAUSTED; holds until the next err

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 in IDLE afterwards; clk_oe=0; dat_oe=0; rx_inhibit=0; done=0; err=0; err_code=0; retry count=0.
- Reset asserted mid-operation releases both lines on the next edge and returns to IDLE with no done/err pulse.
- PS/2 pins pass through a 2-FF synchronizer; fall_pulse = synchronized clock 1 -> 0, one cycle.
- Accept: cmd_valid & cmd_ready at edge T.
  - Latch cmd_byte, cmd_has_arg, cmd_arg; tx_byte = cmd_byte.
  - State goes to INHIBIT; clk_oe=1 from T+1.
- INHIBIT: count INHIBIT_CYC cycles.
  - Last cycle: dat_oe=1 (start bit) while clk_oe is still 1.
  - Next cycle: clk_oe=0, go to SHIFT with bit index 0 and the timeout counter cleared.
- SHIFT: on each fall_pulse, present the next bit.
  - Falling edges 1..8: dat_oe = ~tx_byte[i], LSB first.
  - Edge 9: dat_oe = ~parity, where parity = ~^tx_byte (odd parity).
  - Edge 10: dat_oe=0 (stop bit), go to ACK_WAIT.
- ACK_WAIT: on the next fall_pulse sample synchronized dat.
  - dat=0: ACK, go to RESP_WAIT, clear timeout.
  - dat=1: err NO_ACK, go to IDLE.
- RESP_WAIT, on rx_valid:
  - 0xFA with arg pending: tx_byte = cmd_arg, clear arg pending, retry count=0, go to INHIBIT.
  - 0xFA with no arg pending: done pulse, go to IDLE.
  - 0xFE with retry count < MAX_RETRY: increment retry count, resend the same tx_byte via INHIBIT.
  - 0xFE with retry count = MAX_RETRY: err RESEND_EXHAUSTED, go to IDLE.
  - Any other byte: ignored (scan codes may interleave).
- Timeout:
  - Counter runs in SHIFT, ACK_WAIT and RESP_WAIT.
  - Reaching TIMEOUT_CYC: err TIMEOUT, clk_oe=dat_oe=0, go to IDLE.
  - Counter clears on every state entry and on each fall_pulse in SHIFT.
- cmd_valid while not IDLE: ignored, no queuing.
- done/err pulse in the cycle the state returns to IDLE; cmd_ready=1 the following cycle.
- On exit to IDLE, both oe outputs are 0 on the same edge.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, SHIFT, ACK_WAIT, RESP_WAIT}
  - err_code constants
  - PS2_ACK=8'hFA, PS2_RESEND=8'hFE
- Sub-module ps2_line_sync: 2-FF synchronizers for clk/dat plus the fall_pulse generator. Shared with the receiver.

Test Plan:
- Bench device model (10 kHz clock, latches data on rising edge, ACKs, replies 0xFA): cmd 0xFF, no arg.
  - clk_oe high for exactly 5000 cycles.
  - Model receives 0xFF with parity 1 and sees stop=1.
  - Exactly one done pulse; err never asserts.
- cmd 0xED with arg 0x07, model replies 0xFA to both bytes.
  - Two frames observed: 0xED (parity 1), then 0x07 (parity 0).
  - Single done after the second 0xFA.
- Model replies 0xFE three times, then 0xFA: four 0xED frames, then done.
- Model replies 0xFE four times: four frames sent (original + 3 retries), then err with err_code=3.
- Model omits the line ACK: err with err_code=2 at the 11th falling edge.
- Model never clocks: err with err_code=1 after 1000000 cycles.
- reset pulsed during SHIFT: both oe outputs 0 on the next edge and cmd_ready=1.
- cmd_valid while busy: ignored, no extra frame sent.
